// File: rtl/regfile_sb.sv
// regfile_sb: register file with a per-entry busy scoreboard.
//
// Holds 2**ADDR_W data entries plus one busy bit per entry. A writeback
// stores data and clears the entry's busy bit. An issue reserves an entry by
// setting its busy bit. A flush clears every reservation.
//
// Parameters
//   DATA_W   - data width of each entry
//   ADDR_W   - address width, depth = 2**ADDR_W
//   ZERO_REG - 1: entry 0 reads as zero and is never written or reserved
//   BYPASS   - 1: a same-cycle write is forwarded to matching read ports
//
// Ports
//   clk                 clock, all state updates on the rising edge
//   rst                 asynchronous active-low reset
//   wen/waddr/wdata     writeback port
//   issue_valid/issue_rd destination reservation request
//   flush               clear all reservations (write still performed)
//   raddr_a/raddr_b     combinational read addresses
//   rdata_a/rdata_b     read data
//   busy_a/busy_b       read operand still has a pending producer
//   hazard              busy_a | busy_b
//   busy_cnt            number of entries currently reserved
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic              flush,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic              busy_a,
    output logic              busy_b,
    output logic              hazard,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;

    logic wr_ok;
    logic iss_ok;
    logic byp_a;
    logic byp_b;
    logic zero_a;
    logic zero_b;

    // Writes and reservations aimed at the hardwired zero entry are dropped.
    always_comb begin
        wr_ok  = wen;
        iss_ok = issue_valid && !flush;
        if (ZERO_REG != 0) begin
            if (waddr == '0) begin
                wr_ok = 1'b0;
            end
            if (issue_rd == '0) begin
                iss_ok = 1'b0;
            end
        end
    end

    // Data storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[waddr] <= wdata;
        end
    end

    // Next busy vector: write clears, issue sets afterwards so a same-entry
    // collision leaves the entry reserved. Flush overrides everything.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            if (wr_ok) begin
                busy_d[waddr] = 1'b0;
            end
            if (iss_ok) begin
                busy_d[issue_rd] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Read side.
    always_comb begin
        zero_a = (ZERO_REG != 0) && (raddr_a == '0);
        zero_b = (ZERO_REG != 0) && (raddr_b == '0);
        byp_a  = (BYPASS != 0) && wen && (waddr == raddr_a);
        byp_b  = (BYPASS != 0) && wen && (waddr == raddr_b);
    end

    always_comb begin
        rdata_a = '0;
        busy_a  = 1'b0;
        if (!zero_a) begin
            rdata_a = byp_a ? wdata : mem[raddr_a];
            busy_a  = busy_q[raddr_a] && !byp_a;
        end
    end

    always_comb begin
        rdata_b = '0;
        busy_b  = 1'b0;
        if (!zero_b) begin
            rdata_b = byp_b ? wdata : mem[raddr_b];
            busy_b  = busy_q[raddr_b] && !byp_b;
        end
    end

    assign hazard = busy_a | busy_b;

    // Population count of the registered busy vector.
    always_comb begin
        busy_cnt = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            busy_cnt = busy_cnt + {{ADDR_W{1'b0}}, busy_q[i]};
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Testbench for regfile_sb: a default build (ZERO_REG=1, BYPASS=1) driven by
// a vector table plus a mid-operation reset sequence, and a second build with
// ZERO_REG=0, BYPASS=0 driven by a short hand-written sequence.
module tb_regfile_sb;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    // Default build signals.
    logic        wen, issue_valid, flush;
    logic [4:0]  waddr, issue_rd, raddr_a, raddr_b;
    logic [31:0] wdata;
    logic [31:0] rdata_a, rdata_b;
    logic        busy_a, busy_b, hazard;
    logic [5:0]  busy_cnt;

    // No-bypass / no-zero-register build signals.
    logic        wen1, issue_valid1, flush1;
    logic [4:0]  waddr1, issue_rd1, raddr_a1, raddr_b1;
    logic [31:0] wdata1;
    logic [31:0] rdata_a1, rdata_b1;
    logic        busy_a1, busy_b1, hazard1;
    logic [5:0]  busy_cnt1;

    regfile_sb dut (
        .clk(clk), .rst(rst),
        .wen(wen), .waddr(waddr), .wdata(wdata),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .flush(flush),
        .raddr_a(raddr_a), .raddr_b(raddr_b),
        .rdata_a(rdata_a), .rdata_b(rdata_b),
        .busy_a(busy_a), .busy_b(busy_b), .hazard(hazard),
        .busy_cnt(busy_cnt)
    );

    regfile_sb #(.ZERO_REG(0), .BYPASS(0)) dut1 (
        .clk(clk), .rst(rst),
        .wen(wen1), .waddr(waddr1), .wdata(wdata1),
        .issue_valid(issue_valid1), .issue_rd(issue_rd1), .flush(flush1),
        .raddr_a(raddr_a1), .raddr_b(raddr_b1),
        .rdata_a(rdata_a1), .rdata_b(rdata_b1),
        .busy_a(busy_a1), .busy_b(busy_b1), .hazard(hazard1),
        .busy_cnt(busy_cnt1)
    );

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        iv;
        logic [4:0]  ird;
        logic        fl;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] ea;
        logic        eba;
        logic [31:0] eb;
        logic        ebb;
        logic        ehz;
        logic [5:0]  ecnt;
    } vec_t;

    vec_t tbl [26];

    function automatic vec_t mk(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                                input logic iv, input logic [4:0] ird, input logic fl,
                                input logic [4:0] ra, input logic [4:0] rb,
                                input logic [31:0] ea, input logic eba,
                                input logic [31:0] eb, input logic ebb,
                                input logic ehz, input logic [5:0] ecnt);
        vec_t v;
        v.wen = w;  v.waddr = wa; v.wdata = wd;
        v.iv = iv;  v.ird = ird;  v.fl = fl;
        v.ra = ra;  v.rb = rb;
        v.ea = ea;  v.eba = eba;  v.eb = eb; v.ebb = ebb;
        v.ehz = ehz; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive0(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                          input logic iv, input logic [4:0] ird, input logic fl,
                          input logic [4:0] ra, input logic [4:0] rb);
        wen = w; waddr = wa; wdata = wd;
        issue_valid = iv; issue_rd = ird; flush = fl;
        raddr_a = ra; raddr_b = rb;
    endtask

    task automatic drive1(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                          input logic iv, input logic [4:0] ird,
                          input logic [4:0] ra, input logic [4:0] rb);
        wen1 = w; waddr1 = wa; wdata1 = wd;
        issue_valid1 = iv; issue_rd1 = ird; flush1 = 1'b0;
        raddr_a1 = ra; raddr_b1 = rb;
    endtask

    initial begin
        // Columns: wen waddr wdata | iv ird flush | ra rb | rdata_a busy_a rdata_b busy_b hazard cnt
        tbl[0]  = mk(0, 0,  32'h0,        0, 0,  0, 5,  0,  32'h0,        0, 32'h0,        0, 0, 0);
        tbl[1]  = mk(1, 5,  32'hDEADBEEF, 0, 0,  0, 5,  5,  32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 0, 0);
        tbl[2]  = mk(0, 0,  32'h0,        0, 0,  0, 5,  0,  32'hDEADBEEF, 0, 32'h0,        0, 0, 0);
        tbl[3]  = mk(1, 0,  32'h1234,     1, 0,  0, 0,  0,  32'h0,        0, 32'h0,        0, 0, 0);
        tbl[4]  = mk(0, 0,  32'h0,        0, 0,  0, 0,  0,  32'h0,        0, 32'h0,        0, 0, 0);
        tbl[5]  = mk(0, 0,  32'h0,        1, 7,  0, 7,  5,  32'h0,        0, 32'hDEADBEEF, 0, 0, 0);
        tbl[6]  = mk(0, 0,  32'h0,        0, 0,  0, 7,  7,  32'h0,        1, 32'h0,        1, 1, 1);
        tbl[7]  = mk(1, 7,  32'hA5,       0, 0,  0, 7,  6,  32'hA5,       0, 32'h0,        0, 0, 1);
        tbl[8]  = mk(0, 0,  32'h0,        0, 0,  0, 7,  7,  32'hA5,       0, 32'hA5,       0, 0, 0);
        tbl[9]  = mk(0, 0,  32'h0,        1, 3,  0, 3,  7,  32'h0,        0, 32'hA5,       0, 0, 0);
        tbl[10] = mk(1, 3,  32'h55,       1, 3,  0, 7,  3,  32'hA5,       0, 32'h55,       0, 0, 1);
        tbl[11] = mk(0, 0,  32'h0,        0, 0,  0, 0,  3,  32'h0,        0, 32'h55,       1, 1, 1);
        tbl[12] = mk(1, 3,  32'h66,       0, 0,  0, 3,  3,  32'h66,       0, 32'h66,       0, 0, 1);
        tbl[13] = mk(0, 0,  32'h0,        0, 0,  0, 3,  3,  32'h66,       0, 32'h66,       0, 0, 0);
        tbl[14] = mk(0, 0,  32'h0,        1, 1,  0, 1,  2,  32'h0,        0, 32'h0,        0, 0, 0);
        tbl[15] = mk(0, 0,  32'h0,        1, 2,  0, 1,  2,  32'h0,        1, 32'h0,        0, 1, 1);
        tbl[16] = mk(0, 0,  32'h0,        1, 4,  0, 2,  4,  32'h0,        1, 32'h0,        0, 1, 2);
        tbl[17] = mk(1, 2,  32'h77,       1, 9,  1, 1,  4,  32'h0,        1, 32'h0,        1, 1, 3);
        tbl[18] = mk(0, 0,  32'h0,        0, 0,  0, 9,  2,  32'h0,        0, 32'h77,       0, 0, 0);
        tbl[19] = mk(0, 0,  32'h0,        0, 0,  0, 1,  4,  32'h0,        0, 32'h0,        0, 0, 0);
        tbl[20] = mk(1, 10, 32'h0BAD,     0, 0,  0, 10, 10, 32'h0BAD,     0, 32'h0BAD,     0, 0, 0);
        tbl[21] = mk(0, 0,  32'h0,        0, 0,  0, 10, 1,  32'h0BAD,     0, 32'h0,        0, 0, 0);
        tbl[22] = mk(0, 0,  32'h0,        1, 31, 0, 31, 0,  32'h0,        0, 32'h0,        0, 0, 0);
        tbl[23] = mk(0, 0,  32'h0,        0, 0,  0, 31, 31, 32'h0,        1, 32'h0,        1, 1, 1);
        tbl[24] = mk(1, 31, 32'hFFFFFFFF, 0, 0,  0, 31, 0,  32'hFFFFFFFF, 0, 32'h0,        0, 0, 1);
        tbl[25] = mk(0, 0,  32'h0,        0, 0,  0, 31, 0,  32'hFFFFFFFF, 0, 32'h0,        0, 0, 0);

        drive0(0, 0, 0, 0, 0, 0, 0, 0);
        drive1(0, 0, 0, 0, 0, 0, 0);

        // Reset state.
        repeat (2) @(negedge clk);
        chk("reset busy_cnt", 32'(busy_cnt), 32'd0);
        chk("reset rdata_a", rdata_a, 32'h0);
        rst = 1'b1;

        // Inputs are driven on the falling edge and outputs sampled 2 time
        // units later, before the next rising edge commits the vector.
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            drive0(tbl[i].wen, tbl[i].waddr, tbl[i].wdata, tbl[i].iv, tbl[i].ird,
                   tbl[i].fl, tbl[i].ra, tbl[i].rb);
            #2;
            chk($sformatf("v%0d rdata_a", i), rdata_a, tbl[i].ea);
            chk($sformatf("v%0d busy_a", i), 32'(busy_a), 32'(tbl[i].eba));
            chk($sformatf("v%0d rdata_b", i), rdata_b, tbl[i].eb);
            chk($sformatf("v%0d busy_b", i), 32'(busy_b), 32'(tbl[i].ebb));
            chk($sformatf("v%0d hazard", i), 32'(hazard), 32'(tbl[i].ehz));
            chk($sformatf("v%0d busy_cnt", i), 32'(busy_cnt), 32'(tbl[i].ecnt));
        end

        // Reset asserted mid-operation with a write and issue pending.
        @(negedge clk);
        drive0(0, 0, 0, 1, 12, 0, 5, 12);
        #2;
        chk("mr pre busy_b", 32'(busy_b), 32'd0);
        @(negedge clk);
        drive0(0, 0, 0, 0, 0, 0, 5, 12);
        #2;
        chk("mr held rdata_a", rdata_a, 32'hDEADBEEF);
        chk("mr held busy_b", 32'(busy_b), 32'd1);
        chk("mr held busy_cnt", 32'(busy_cnt), 32'd1);
        #1;
        rst = 1'b0;
        drive0(1, 8, 32'hCAFE, 1, 13, 0, 5, 12);
        #1;
        chk("mr async rdata_a", rdata_a, 32'h0);
        chk("mr async busy_b", 32'(busy_b), 32'd0);
        chk("mr async busy_cnt", 32'(busy_cnt), 32'd0);
        @(posedge clk);
        #1;
        chk("mr edge busy_cnt", 32'(busy_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        drive0(0, 0, 0, 0, 0, 0, 8, 13);
        #2;
        chk("mr discard rdata_a", rdata_a, 32'h0);
        chk("mr discard busy_b", 32'(busy_b), 32'd0);
        chk("mr discard busy_cnt", 32'(busy_cnt), 32'd0);
        @(negedge clk);
        drive0(1, 8, 32'h42, 0, 0, 0, 5, 12);
        #2;
        chk("mr cleared rdata_a", rdata_a, 32'h0);
        @(negedge clk);
        drive0(0, 0, 0, 0, 0, 0, 8, 0);
        #2;
        chk("mr resume rdata_a", rdata_a, 32'h42);

        // Build without bypass and without a hardwired zero entry.
        @(negedge clk);
        drive1(1, 6, 32'h11, 0, 0, 6, 6);
        #2;
        chk("nb first rdata_a", rdata_a1, 32'h0);
        @(negedge clk);
        drive1(0, 0, 0, 1, 6, 6, 6);
        #2;
        chk("nb stored rdata_a", rdata_a1, 32'h11);
        chk("nb pre busy_a", 32'(busy_a1), 32'd0);
        @(negedge clk);
        drive1(1, 6, 32'h99, 0, 0, 6, 6);
        #2;
        chk("nb old rdata_a", rdata_a1, 32'h11);
        chk("nb busy_a", 32'(busy_a1), 32'd1);
        chk("nb busy_b", 32'(busy_b1), 32'd1);
        chk("nb hazard", 32'(hazard1), 32'd1);
        chk("nb busy_cnt", 32'(busy_cnt1), 32'd1);
        @(negedge clk);
        drive1(0, 0, 0, 0, 0, 6, 6);
        #2;
        chk("nb new rdata_a", rdata_a1, 32'h99);
        chk("nb clr busy_a", 32'(busy_a1), 32'd0);
        chk("nb clr busy_cnt", 32'(busy_cnt1), 32'd0);
        @(negedge clk);
        drive1(1, 0, 32'h5A, 1, 0, 0, 0);
        #2;
        chk("nz pre rdata_a", rdata_a1, 32'h0);
        @(negedge clk);
        drive1(0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("nz rdata_a", rdata_a1, 32'h5A);
        chk("nz busy_a", 32'(busy_a1), 32'd1);
        chk("nz busy_cnt", 32'(busy_cnt1), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
